// File: rtl/fir_hls_mul_pipe_rs.sv
// -----------------------------------------------------------------------------
// fir_hls_mul_pipe_rs
//   Pipelined signed multiplier (sample x coefficient) for the transposed-FIR
//   datapath. The full product is requantised by an arithmetic right shift with
//   optional round-half-up and optional saturation. A saturating counter tracks
//   clipped beats that have been delivered downstream.
//
//   Handshake: a beat moves from producer to this block when in_valid && in_ready,
//   and from this block to the consumer when out_valid && out_ready. The whole
//   pipeline advances as one unit (adv = ce && (!out_valid || out_ready)), so a
//   stalled output freezes every stage. Bubbles are not compressed.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, dominates ce
//   ce         in   clock enable, low freezes all state and forces in_ready low
//   in_valid   in   din0/din1 valid
//   in_ready   out  beat accepted when in_valid && in_ready (combinational)
//   din0       in   signed sample
//   din1       in   signed coefficient
//   out_valid  out  dout valid
//   out_ready  in   consumer accepts when out_valid && out_ready
//   dout       out  requantised signed product
//   sat_flag   out  dout of this beat was clipped (always 0 when SAT=0)
//   sat_count  out  number of clipped beats delivered, sticks at all-ones
// -----------------------------------------------------------------------------
module fir_hls_mul_pipe_rs #(
    parameter int DIN0_WIDTH    = 16,
    parameter int DIN1_WIDTH    = 14,
    parameter int DOUT_WIDTH    = 16,
    parameter int NUM_STAGE     = 3,
    parameter int SHIFT         = 13,
    parameter int ROUND         = 1,
    parameter int SAT           = 1,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         sat_flag,
    output logic [SAT_CNT_WIDTH-1:0]     sat_count
);

    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
    // One guard bit above the product absorbs the rounding carry; the extra
    // width keeps the clip bounds representable when DOUT_WIDTH is large.
    localparam int EW  = (PW + 1 > DOUT_WIDTH + 1) ? PW + 1 : DOUT_WIDTH + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ? (EW'(1) << RSH) : '0;
    localparam logic signed [EW-1:0] DMAX = {{(EW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] DMIN = {{(EW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    logic                         w_adv;
    logic signed [PW-1:0]         w_fin_p;   // product feeding the output stage
    logic                         w_fin_v;   // valid bit feeding the output stage
    logic signed [EW-1:0]         w_ext;
    logic signed [EW-1:0]         w_shr;
    logic signed [DOUT_WIDTH-1:0] w_q;
    logic                         w_clip;

    logic                         r_out_valid;
    logic signed [DOUT_WIDTH-1:0] r_dout;
    logic                         r_sat;
    logic [SAT_CNT_WIDTH-1:0]     r_sat_cnt;

    assign w_adv    = ce && (!r_out_valid || out_ready);
    assign in_ready = w_adv;

    generate
        if (NUM_STAGE == 1) begin : g_ns1
            // Single register: everything happens between the ports and the output stage.
            assign w_fin_p = PW'(din0) * PW'(din1);
            assign w_fin_v = in_valid;
        end else begin : g_ops
            logic signed [DIN0_WIDTH-1:0] r_a;
            logic signed [DIN1_WIDTH-1:0] r_b;
            logic                         r_v;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_v <= in_valid;
                    r_a <= din0;
                    r_b <= din1;
                end
            end

            if (NUM_STAGE == 2) begin : g_ns2
                assign w_fin_p = PW'(r_a) * PW'(r_b);
                assign w_fin_v = r_v;
            end else begin : g_pipe
                // Stage 2 registers the product; later stages only delay it so
                // the requantiser always sits in front of the output register.
                localparam int D = NUM_STAGE - 2;
                logic signed [PW-1:0] r_p [D];
                logic [D-1:0]         r_pv;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_pv <= '0;
                        for (int i = 0; i < D; i++) r_p[i] <= '0;
                    end else if (w_adv) begin
                        r_p[0]  <= PW'(r_a) * PW'(r_b);
                        r_pv[0] <= r_v;
                        for (int i = 1; i < D; i++) begin
                            r_p[i]  <= r_p[i-1];
                            r_pv[i] <= r_pv[i-1];
                        end
                    end
                end

                assign w_fin_p = r_p[D-1];
                assign w_fin_v = r_pv[D-1];
            end
        end
    endgenerate

    // Requantiser: sign-extend, add the half-LSB (if rounding), shift, clip or wrap.
    always_comb begin
        w_ext  = EW'(w_fin_p) + RND;
        w_shr  = w_ext >>> SHIFT;
        w_q    = w_shr[DOUT_WIDTH-1:0];
        w_clip = 1'b0;
        if (SAT != 0) begin
            if (w_shr > DMAX) begin
                w_q    = DMAX[DOUT_WIDTH-1:0];
                w_clip = 1'b1;
            end else if (w_shr < DMIN) begin
                w_q    = DMIN[DOUT_WIDTH-1:0];
                w_clip = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_sat       <= 1'b0;
            r_sat_cnt   <= '0;
        end else if (w_adv) begin
            // adv with out_valid high implies out_ready: the held beat is delivered now.
            if (r_out_valid && r_sat && (r_sat_cnt != '1)) begin
                r_sat_cnt <= r_sat_cnt + SAT_CNT_WIDTH'(1);
            end
            r_out_valid <= w_fin_v;
            // Data only moves with a real beat, so a bubble leaves the last result visible.
            if (w_fin_v) begin
                r_dout <= w_q;
                r_sat  <= w_clip;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign sat_flag  = r_sat;
    assign sat_count = r_sat_cnt;

endmodule

// File: tb/tb_fir_hls_mul_pipe_rs.sv
// Three instances: 0 = defaults (3 stages, round, saturate),
// 1 = 1 stage, truncate, wrap; 2 = 5 stages, round, saturate.
module tb_fir_hls_mul_pipe_rs;

    logic clk;
    logic rst  [3];
    logic ce   [3];
    logic iv   [3];
    logic ir   [3];
    logic ordy [3];
    logic ov   [3];
    logic so   [3];
    logic signed [15:0] d0   [3];
    logic signed [13:0] d1   [3];
    logic signed [15:0] dout [3];
    logic [15:0]        sc   [3];

    int P_NS [3] = '{3, 1, 5};
    int P_R  [3] = '{1, 0, 1};
    int P_S  [3] = '{1, 0, 1};

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    logic g_acc, g_del, g_hold, g_ir, g_ov, g_sat;
    logic signed [15:0] g_dout;
    logic [15:0] g_sc;

    logic [16:0] exp_q [$];   // {sat_flag, dout}
    int exp_sc [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fir_hls_mul_pipe_rs #(.NUM_STAGE(3)) u_dut0 (
        .clk(clk), .reset(rst[0]), .ce(ce[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .din0(d0[0]), .din1(d1[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .dout(dout[0]), .sat_flag(so[0]), .sat_count(sc[0]));

    fir_hls_mul_pipe_rs #(.NUM_STAGE(1), .ROUND(0), .SAT(0)) u_dut1 (
        .clk(clk), .reset(rst[1]), .ce(ce[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .din0(d0[1]), .din1(d1[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .dout(dout[1]), .sat_flag(so[1]), .sat_count(sc[1]));

    fir_hls_mul_pipe_rs #(.NUM_STAGE(5)) u_dut2 (
        .clk(clk), .reset(rst[2]), .ce(ce[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .din0(d0[2]), .din1(d1[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .dout(dout[2]), .sat_flag(so[2]), .sat_count(sc[2]));

    // Reference: exact product, optional +half LSB, floor division by 2^13, clip or wrap.
    function automatic logic [16:0] ref_q(input int a, input int b, input int rnd, input int sat);
        longint p;
        longint q;
        logic [63:0] qb;
        p = longint'(a) * longint'(b);
        if (rnd != 0) p = p + 4096;
        if (p >= 0) q = p / 8192;
        else        q = -((-p + 8191) / 8192);
        if (sat != 0 && q > 32767)  return {1'b1, 16'h7fff};
        if (sat != 0 && q < -32768) return {1'b1, 16'h8000};
        qb = q;
        return {1'b0, qb[15:0]};
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; ce[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b1;
            d0[k] = '0; d1[k] = '0;
        end
    endtask

    // One clock: sample handshake just before the edge, return #1 after it.
    task automatic cyc(input int k);
        #1;
        g_ir   = ir[k];
        g_ov   = ov[k];
        g_acc  = iv[k] && ir[k];
        g_del  = ov[k] && ordy[k] && ce[k];
        g_hold = ov[k] && !(ordy[k] && ce[k]);
        g_dout = dout[k];
        g_sat  = so[k];
        g_sc   = sc[k];
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        cyc(0);
        for (int k = 0; k < 3; k++) begin rst[k] = 1'b0; exp_sc[k] = 0; end
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle_all();
        for (int k = 0; k < 3; k++) begin rst[k] = 1'b1; iv[k] = 1'b1; d0[k] = 16'sd100; d1[k] = 14'sd100; end
        cyc(0);
        cyc(0);
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            checks++; if (ov[k] !== 1'b0)    begin failures++; $display("FAIL reset_out_valid k=%0d got=%0d exp=0", k, ov[k]); end
            checks++; if (dout[k] !== 16'sd0) begin failures++; $display("FAIL reset_dout k=%0d got=%0d exp=0", k, dout[k]); end
            checks++; if (so[k] !== 1'b0)    begin failures++; $display("FAIL reset_sat_flag k=%0d got=%0d exp=0", k, so[k]); end
            checks++; if (sc[k] !== 16'd0)   begin failures++; $display("FAIL reset_sat_count k=%0d got=%0d exp=0", k, sc[k]); end
            checks++; if (ir[k] !== 1'b1)    begin failures++; $display("FAIL reset_in_ready k=%0d got=%0d exp=1", k, ir[k]); end
        end
        for (int k = 0; k < 3; k++) begin rst[k] = 1'b0; exp_sc[k] = 0; end
    endtask

    // Directed arithmetic values and single-beat latency per instance.
    task automatic test_arith();
        int t_k [8] = '{0, 0, 0, 0, 1, 1, 1, 2};
        int t_a [8] = '{5, -5, -32768, 32767, 5, -5, -32768, 5};
        int t_b [8] = '{4096, 4096, -8192, -8192, 4096, 4096, -8192, 4096};
        int t_d [8] = '{3, -2, 32767, -32767, 2, -3, -32768, 3};
        int t_s [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        int k;
        int lat;
        idle_all();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            k = t_k[i];
            iv[k] = 1'b1; d0[k] = 16'(t_a[i]); d1[k] = 14'(t_b[i]);
            cyc(k);
            iv[k] = 1'b0;
            checks++; if (g_acc !== 1'b1) begin failures++; $display("FAIL arith_accept row=%0d got=%0d exp=1", i, g_acc); end
            lat = 1;
            while (ov[k] !== 1'b1 && lat < 20) begin cyc(k); lat++; end
            checks++; if (lat != P_NS[k]) begin failures++; $display("FAIL arith_latency row=%0d got=%0d exp=%0d", i, lat, P_NS[k]); end
            checks++; if (dout[k] !== 16'(t_d[i])) begin failures++; $display("FAIL arith_dout row=%0d got=%0d exp=%0d", i, dout[k], t_d[i]); end
            checks++; if (so[k] !== 1'(t_s[i])) begin failures++; $display("FAIL arith_sat_flag row=%0d got=%0d exp=%0d", i, so[k], t_s[i]); end
            cyc(k);
            if (t_s[i] != 0) exp_sc[k]++;
            checks++; if (sc[k] !== 16'(exp_sc[k])) begin failures++; $display("FAIL arith_sat_count row=%0d got=%0d exp=%0d", i, sc[k], exp_sc[k]); end
        end
    endtask

    // 8 back-to-back beats with a 3-cycle output stall. din1=8191 (~1.0 in Q1.13).
    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        int n    = 0;
        logic [16:0] e;
        idle_all();
        do_reset();
        while (got < 8 && n < 80) begin
            ordy[0] = !(n >= 4 && n < 7);
            iv[0]   = (sent < 8);
            d0[0]   = 16'(sent + 1);
            d1[0]   = 14'sd8191;
            cyc(0);
            if (g_acc) begin exp_q.push_back(ref_q(sent + 1, 8191, 1, 1)); sent++; end
            if (g_hold) begin
                checks++; if (g_ir !== 1'b0) begin failures++; $display("FAIL bp_in_ready n=%0d got=%0d exp=0", n, g_ir); end
                checks++; if (ov[0] !== 1'b1 || dout[0] !== g_dout) begin failures++; $display("FAIL bp_stable n=%0d got=%0d exp=%0d", n, dout[0], g_dout); end
            end
            if (g_del) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%0d exp=none", g_dout); end
                else begin
                    e = exp_q.pop_front();
                    if (g_dout !== e[15:0] || g_dout !== 16'(got + 1)) begin
                        failures++; $display("FAIL bp_dout idx=%0d got=%0d exp=%0d", got, g_dout, got + 1);
                    end
                end
                got++;
            end
            n++;
        end
        iv[0] = 1'b0;
        checks++; if (got != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got); end
    endtask

    // 4 cycles of ce=0 mid-stream on the 5-stage instance.
    task automatic test_clock_enable();
        int sent = 0;
        int got  = 0;
        int n    = 0;
        logic [16:0] e;
        idle_all();
        do_reset();
        while (got < 10 && n < 80) begin
            ce[2] = !(n >= 6 && n < 10);
            iv[2] = (sent < 10);
            d0[2] = 16'($urandom);
            d1[2] = 14'($urandom);
            cyc(2);
            if (!ce[2]) begin
                checks++; if (g_ir !== 1'b0) begin failures++; $display("FAIL ce_in_ready n=%0d got=%0d exp=0", n, g_ir); end
                checks++; if (ov[2] !== g_ov || dout[2] !== g_dout || sc[2] !== g_sc) begin
                    failures++; $display("FAIL ce_frozen n=%0d got=%0d exp=%0d", n, dout[2], g_dout);
                end
            end
            if (g_acc) begin exp_q.push_back(ref_q(int'(d0[2]), int'(d1[2]), 1, 1)); sent++; end
            if (g_del) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL ce_extra got=%0d exp=none", g_dout); end
                else begin
                    e = exp_q.pop_front();
                    if ({g_sat, g_dout} !== e) begin failures++; $display("FAIL ce_dout idx=%0d got=%0d exp=%0d", got, g_dout, $signed(e[15:0])); end
                end
                got++;
            end
            n++;
        end
        ce[2] = 1'b1; iv[2] = 1'b0;
        checks++; if (got != 10) begin failures++; $display("FAIL ce_count got=%0d exp=10", got); end
    endtask

    // Random valid/ready/ce and data on each instance against the queue model.
    task automatic test_random();
        logic [16:0] e;
        int drain;
        for (int k = 0; k < 3; k++) begin
            idle_all();
            do_reset();
            for (int n = 0; n < 300; n++) begin
                ce[k]   = ($urandom_range(0, 9) != 0);
                iv[k]   = $urandom_range(0, 1) == 1;
                ordy[k] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) begin d0[k] = -16'sd32768; d1[k] = -14'sd8192; end
                else begin d0[k] = 16'($urandom); d1[k] = 14'($urandom); end
                cyc(k);
                if (!ce[k]) begin
                    checks++; if (g_ir !== 1'b0) begin failures++; $display("FAIL rnd_ce_ready k=%0d got=%0d exp=0", k, g_ir); end
                end
                if (g_acc) exp_q.push_back(ref_q(int'(d0[k]), int'(d1[k]), P_R[k], P_S[k]));
                if (g_hold) begin
                    checks++; if (ov[k] !== 1'b1 || dout[k] !== g_dout || so[k] !== g_sat) begin
                        failures++; $display("FAIL rnd_hold k=%0d got=%0d exp=%0d", k, dout[k], g_dout);
                    end
                end
                if (g_del) begin
                    checks++;
                    if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_extra k=%0d got=%0d exp=none", k, g_dout); end
                    else begin
                        e = exp_q.pop_front();
                        if (e[16]) exp_sc[k]++;
                        if ({g_sat, g_dout} !== e) begin
                            failures++; $display("FAIL rnd_dout k=%0d got=%0d/%0d exp=%0d/%0d", k, g_dout, g_sat, $signed(e[15:0]), e[16]);
                        end
                    end
                end
            end
            ce[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b1;
            drain = 0;
            while (drain < 20) begin
                cyc(k);
                if (g_del) begin
                    checks++;
                    if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_extra k=%0d got=%0d exp=none", k, g_dout); end
                    else begin
                        e = exp_q.pop_front();
                        if (e[16]) exp_sc[k]++;
                        if ({g_sat, g_dout} !== e) begin
                            failures++; $display("FAIL rnd_dout k=%0d got=%0d exp=%0d", k, g_dout, $signed(e[15:0]));
                        end
                    end
                end
                drain++;
            end
            checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_lost k=%0d got=%0d exp=0", k, exp_q.size()); end
            checks++; if (sc[k] !== 16'(exp_sc[k])) begin failures++; $display("FAIL rnd_sat_count k=%0d got=%0d exp=%0d", k, sc[k], exp_sc[k]); end
        end
    endtask

    // Reset with 3 beats in flight after 5 clipped beats were delivered.
    task automatic test_reset_inflight();
        int sent = 0;
        int got  = 0;
        int n    = 0;
        int seen = 0;
        idle_all();
        do_reset();
        d0[0] = -16'sd32768; d1[0] = -14'sd8192;
        while (got < 5 && n < 60) begin
            iv[0] = (sent < 5);
            cyc(0);
            if (g_acc) sent++;
            if (g_del) got++;
            n++;
        end
        iv[0] = 1'b0;
        checks++; if (sc[0] !== 16'd5) begin failures++; $display("FAIL inflight_sat_count got=%0d exp=5", sc[0]); end
        d0[0] = 16'sd1000; d1[0] = 14'sd4096;
        sent = 0; n = 0;
        while (sent < 3 && n < 20) begin
            iv[0] = 1'b1;
            cyc(0);
            if (g_acc) sent++;
            n++;
        end
        iv[0] = 1'b0; rst[0] = 1'b1;
        cyc(0);
        rst[0] = 1'b0;
        checks++; if (ov[0] !== 1'b0)     begin failures++; $display("FAIL inflight_out_valid got=%0d exp=0", ov[0]); end
        checks++; if (dout[0] !== 16'sd0) begin failures++; $display("FAIL inflight_dout got=%0d exp=0", dout[0]); end
        checks++; if (sc[0] !== 16'd0)    begin failures++; $display("FAIL inflight_sat_count got=%0d exp=0", sc[0]); end
        for (int i = 0; i < 10; i++) begin
            cyc(0);
            if (ov[0] === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL inflight_stale got=%0d exp=0", seen); end
    endtask

    initial begin
        idle_all();
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_arith();
        test_back_to_back();
        test_clock_enable();
        test_random();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
